// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared FSM encoding and timing constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;
  localparam int SRAM_WAIT_DEF = 5;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sram_port_arbiter_wait_counter.sv
// wait_counter: loadable down-counter timing one SRAM access, with a zero flag.
module wait_counter
  import sram_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between fetch and data stages, data first.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              freeze_if,
  output logic              freeze_mem
);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(SRAM_WAIT - 1);
  state_t state, next;
  logic we_q, cancel, zero, grant, busy, fin_if, fin_mem;
  assign grant      = state == IDLE && (if_req || mem_req);
  assign busy       = state == BUSY_IF || state == BUSY_MEM;
  assign fin_if     = state == BUSY_IF && zero;
  assign fin_mem    = state == BUSY_MEM && zero;
  assign sram_we    = state == BUSY_MEM && we_q;
  assign freeze_mem = mem_req && !mem_ready;
  assign freeze_if  = (if_req && !if_ready) || freeze_mem;
  wait_counter u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (WAIT_LD),
    .dec      (busy && !zero),
    .zero     (zero)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE:             next = mem_req ? BUSY_MEM : if_req ? BUSY_IF : IDLE;
      BUSY_IF, BUSY_MEM: next = zero ? DONE : state;
      default:          next = IDLE;
    endcase
  end
  // A flush arriving in the final wait cycle must still cancel this fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      we_q       <= 1'b0;
    end else begin
      state     <= next;
      cancel    <= state == BUSY_IF && (cancel || if_flush);
      if_ready  <= fin_if && !cancel && !if_flush;
      mem_ready <= fin_mem;
      if (fin_if && !cancel && !if_flush) if_rdata <= sram_rdata;
      if (fin_mem && !we_q) mem_rdata <= sram_rdata;
      if (grant) begin
        sram_addr  <= mem_req ? mem_addr : if_addr;
        sram_wdata <= mem_wdata;
        we_q       <= mem_req && mem_we;
      end
    end
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning SRAM word width.
REQ-003 SHALL have parameter SRAM_WAIT, default 5, meaning cycles per SRAM access (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port if_req, input, 1, meaning instruction-fetch read request.
REQ-007 SHALL have port if_addr, input, ADDR_W, meaning fetch address.
REQ-008 SHALL have port if_flush, input, 1, meaning branch taken; cancel the fetch in flight.
REQ-009 SHALL have port if_ready, output, 1, meaning a one-cycle pulse when if_rdata is valid.
REQ-010 SHALL have port if_rdata, output, DATA_W, meaning fetched instruction word.
REQ-011 SHALL have port mem_req, input, 1, meaning data-stage access request.
REQ-012 SHALL have port mem_we, input, 1, meaning 1 = write, 0 = read.
REQ-013 SHALL have port mem_addr and mem_wdata, input, ADDR_W/DATA_W, meaning data-stage address and write data.
REQ-014 SHALL have port mem_ready and mem_rdata, output, 1/DATA_W, meaning done pulse and read data.
REQ-015 SHALL have port sram_addr, sram_wdata and sram_we, output, ADDR_W/DATA_W/1, meaning SRAM command bus.
REQ-016 SHALL have port sram_rdata, input, DATA_W, meaning SRAM read data, valid in the final wait cycle.
REQ-017 SHALL have port freeze_if and freeze_mem, output, 1 each, meaning stage stall requests to the pipeline.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM, DONE.
REQ-019 SHALL grant in IDLE: mem_req takes priority over if_req; grant goes to BUSY_MEM or BUSY_IF.
REQ-020 SHALL grant nothing in IDLE when neither request is set, and stay in IDLE.
REQ-021 SHALL latch the granted address, wdata and we at grant, and drive them on sram_* for the whole access; requester inputs are ignored until DONE.
REQ-022 SHALL assert sram_we only in BUSY_MEM with a latched write; sram_we is 0 in all other states.
REQ-023 SHALL load a 4-bit wait counter with SRAM_WAIT-1 at grant and decrement it each BUSY cycle; the access ends when the counter reaches 0.
REQ-024 SHALL capture sram_rdata into the owner's rdata register and go to DONE at the end of the access.
REQ-025 SHALL pulse the owner's ready for exactly the one DONE cycle; DONE always returns to IDLE, so two accesses are separated by at least one idle cycle.
REQ-026 SHALL give grant-to-ready latency of SRAM_WAIT+1 cycles; requesters hold req until ready.
REQ-027 SHALL hold if_rdata and mem_rdata stable until the next completion by the same owner.
REQ-028 SHALL keep freeze_mem = mem_req AND NOT mem_ready at all times.
REQ-029 SHALL keep freeze_if = (if_req AND NOT if_ready) OR freeze_mem, so a data stall also stalls fetch.
REQ-030 SHALL set a cancel flag when if_flush occurs during BUSY_IF; the access still completes, but if_ready is suppressed in DONE and the flag is cleared.
REQ-031 SHALL ignore if_flush in IDLE and in BUSY_MEM.
REQ-032 SHALL grant the MEM requester at the next IDLE when both requests rise in the same cycle; the fetch waits.
REQ-033 SHALL apply no special state change for a write; mem_ready still pulses and mem_rdata is unchanged.

Reset
REQ-034 SHALL, while rst_n = 0, force: state IDLE, counter 0, cancel flag 0, if_ready 0, mem_ready 0, rdata registers 0, sram_we 0, sram_addr 0, sram_wdata 0.
REQ-035 SHALL abort any access in progress when reset asserts mid-access, with no ready pulse after release.
REQ-036 SHALL allow a grant in the first clock edge after rst_n deasserts.

Structure
REQ-037 SHALL define the FSM state encoding and the SRAM_WAIT default in the shared pipeline package.
REQ-038 SHALL use one sub-module, wait_counter (load, decrement, zero flag), instantiated once.
REQ-039 SHALL keep the remaining logic flat in sram_port_arbiter.

Verification
REQ-040 SHALL cover an IF read alone: if_req=1, if_addr=0x0010, sram_rdata=0xE3A01005 -> if_ready pulses at cycle 6 after grant, if_rdata=0xE3A01005, freeze_if=1 for cycles 0-5.
REQ-041 SHALL cover a simultaneous request: if_req and mem_req rise together -> MEM served first; IF ready 7 cycles after mem_ready; freeze_if high throughout.
REQ-042 SHALL cover a MEM write: mem_we=1, mem_addr=0x0100, mem_wdata=0xDEADBEEF -> sram_we=1 for exactly 5 cycles with those values; mem_ready one pulse; mem_rdata unchanged.
REQ-043 SHALL cover a flush: if_flush pulsed in BUSY_IF cycle 2 -> no if_ready, FSM back in IDLE 7 cycles after grant, next if_req served normally.
REQ-044 SHALL cover reset mid-operation: rst_n=0 in BUSY_MEM cycle 3 -> all outputs 0 immediately (asynchronously), no mem_ready after release, new grant on the first edge after release.
REQ-045 SHALL cover SRAM_WAIT=1: a back-to-back IF stream gives if_ready every 3 cycles.
